// File: rtl/arb_mux_reg_if.sv
// rtl/arb_mux_reg_if.sv - request/response bundle shared by the producers and the arbitrating output register
interface arb_mux_reg_if #(
  parameter int N     = 4,
  parameter int WIDTH = 32
);
  localparam int SEL_W = (N > 1) ? $clog2(N) : 1;

  logic [N-1:0]       in_valid;
  logic [N*WIDTH-1:0] in_data;
  logic [N-1:0]       in_ready;
  logic               out_valid;
  logic [WIDTH-1:0]   out_data;
  logic [SEL_W-1:0]   out_src;
  logic               out_ready;

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, out_src
  );

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, out_src
  );
endinterface

// File: rtl/arb_mux_reg.sv
// rtl/arb_mux_reg.sv - N-way round-robin or fixed-priority arbiter feeding one registered output slot
module arb_mux_reg #(
  parameter int N          = 4,
  parameter int WIDTH      = 32,
  parameter int FIXED_PRIO = 0
) (
  input logic           clk,
  input logic           rst,
  arb_mux_reg_if.slave  bus
);
  localparam int SEL_W = (N > 1) ? $clog2(N) : 1;
  localparam logic [SEL_W:0] N_W = (SEL_W + 1)'(N);

  logic [SEL_W-1:0] ptr;
  logic             out_valid_q;
  logic [WIDTH-1:0] out_data_q;
  logic [SEL_W-1:0] out_src_q;

  logic [2*N-1:0]   rot;
  logic             found;
  logic [SEL_W-1:0] off;
  logic [SEL_W:0]   sum;
  logic [SEL_W-1:0] gnt_idx;
  logic [WIDTH-1:0] gnt_data;
  logic [SEL_W:0]   nxt;
  logic             can_accept;
  logic             take;
  logic [N-1:0]     in_ready_c;

  assign can_accept = !out_valid_q || bus.out_ready;

  // Rotate requests so the search always starts at bit 0; ptr is pinned at 0 in fixed mode.
  always_comb begin
    rot   = {bus.in_valid, bus.in_valid} >> ptr;
    found = 1'b0;
    off   = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (rot[i]) begin
        found = 1'b1;
        off   = SEL_W'(i);
      end
    end
    sum = {1'b0, ptr} + {1'b0, off};
    if (sum >= N_W) sum = sum - N_W;
    gnt_idx = sum[SEL_W-1:0];
    nxt = {1'b0, gnt_idx} + (SEL_W + 1)'(1);
    if (nxt == N_W) nxt = '0;
  end

  assign take = found && can_accept && !rst;

  always_comb begin
    gnt_data   = '0;
    in_ready_c = '0;
    for (int i = 0; i < N; i++) begin
      if (gnt_idx == SEL_W'(i)) begin
        gnt_data      = bus.in_data[i*WIDTH +: WIDTH];
        in_ready_c[i] = take;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_src_q   <= '0;
      ptr         <= '0;
    end else if (take) begin
      out_valid_q <= 1'b1;
      out_data_q  <= gnt_data;
      out_src_q   <= gnt_idx;
      if (FIXED_PRIO == 0) ptr <= nxt[SEL_W-1:0];
    end else if (bus.out_ready) begin
      out_valid_q <= 1'b0;
    end
  end

  assign bus.in_ready  = in_ready_c;
  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign bus.out_src   = out_src_q;
endmodule

// File: tb/tb_arb_mux_reg.sv
// tb/tb_arb_mux_reg.sv - directed-vector bench for arb_mux_reg in round-robin, fixed-priority and N=3 builds
module tb_arb_mux_reg;
  logic clk;
  logic rst;
  int checks = 0;
  int passed = 0;

  arb_mux_reg_if #(.N(4), .WIDTH(32)) rr ();
  arb_mux_reg_if #(.N(4), .WIDTH(32)) fp ();
  arb_mux_reg_if #(.N(3), .WIDTH(8))  n3 ();

  arb_mux_reg #(.N(4), .WIDTH(32), .FIXED_PRIO(0)) dut_rr (.clk(clk), .rst(rst), .bus(rr));
  arb_mux_reg #(.N(4), .WIDTH(32), .FIXED_PRIO(1)) dut_fp (.clk(clk), .rst(rst), .bus(fp));
  arb_mux_reg #(.N(3), .WIDTH(8),  .FIXED_PRIO(0)) dut_n3 (.clk(clk), .rst(rst), .bus(n3));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    rr.in_valid = 4'hF; rr.out_ready = 1'b1;
    #1;
    checks++; if (rr.in_ready !== 4'b0000) $display("FAIL reset_in_ready got %b want 0000", rr.in_ready); else passed++;
    step(); step();
    checks++; if (rr.out_valid !== 1'b0 || rr.out_data !== 32'h0 || rr.out_src !== 2'd0)
      $display("FAIL reset_out got v=%b d=%h s=%0d want v=0 d=0 s=0", rr.out_valid, rr.out_data, rr.out_src); else passed++;
    checks++; if (dut_rr.ptr !== 2'd0) $display("FAIL reset_ptr got %0d want 0", dut_rr.ptr); else passed++;
    checks++; if (fp.out_valid !== 1'b0 || n3.out_valid !== 1'b0)
      $display("FAIL reset_other_valid got fp=%b n3=%b want 0 0", fp.out_valid, n3.out_valid); else passed++;
    rr.in_valid = 4'h0;
    rst = 1'b0;
    step();
  endtask

  task automatic test_round_robin();
    logic [31:0] dv [4];
    logic [1:0]  es [5];
    dv = '{32'h000000FF, 32'h0000FF00, 32'h00FF0000, 32'hFF000000};
    es = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
    for (int c = 0; c < 4; c++) rr.in_data[c*32 +: 32] = dv[c];
    rr.in_valid = 4'hF; rr.out_ready = 1'b1;
    #1;
    for (int k = 0; k < 5; k++) begin
      checks++; if (rr.in_ready !== (4'b0001 << es[k])) $display("FAIL rr_in_ready[%0d] got %b want %b", k, rr.in_ready, 4'b0001 << es[k]); else passed++;
      step();
      checks++; if (rr.out_valid !== 1'b1 || rr.out_src !== es[k] || rr.out_data !== dv[es[k]])
        $display("FAIL rr_out[%0d] got v=%b s=%0d d=%h want v=1 s=%0d d=%h", k, rr.out_valid, rr.out_src, rr.out_data, es[k], dv[es[k]]); else passed++;
    end
  endtask

  task automatic test_stall();
    rr.in_valid = 4'h0;
    step();
    checks++; if (rr.out_valid !== 1'b0) $display("FAIL stall_predrain got v=%b want 0", rr.out_valid); else passed++;
    rr.in_data[2*32 +: 32] = 32'hDEADBEEF;
    rr.in_valid = 4'b0100; rr.out_ready = 1'b0;
    step();
    for (int j = 0; j < 3; j++) begin
      checks++; if (rr.out_valid !== 1'b1 || rr.out_data !== 32'hDEADBEEF || rr.out_src !== 2'd2 || rr.in_ready !== 4'b0000)
        $display("FAIL stall_hold[%0d] got v=%b d=%h s=%0d r=%b want v=1 d=deadbeef s=2 r=0000", j, rr.out_valid, rr.out_data, rr.out_src, rr.in_ready); else passed++;
      step();
    end
    rr.in_valid = 4'h0; rr.out_ready = 1'b1;
    step();
    checks++; if (rr.out_valid !== 1'b0 || rr.out_data !== 32'hDEADBEEF || dut_rr.ptr !== 2'd3)
      $display("FAIL stall_drain got v=%b d=%h ptr=%0d want v=0 d=deadbeef ptr=3", rr.out_valid, rr.out_data, dut_rr.ptr); else passed++;
  endtask

  task automatic test_wrap();
    logic [1:0]  es [3];
    logic [31:0] ed [3];
    es = '{2'd3, 2'd1, 2'd3};
    ed = '{32'h33333333, 32'h11111111, 32'h33333333};
    rr.in_data[1*32 +: 32] = 32'h11111111;
    rr.in_data[3*32 +: 32] = 32'h33333333;
    rr.in_valid = 4'b0010;
    step();
    checks++; if (dut_rr.ptr !== 2'd2) $display("FAIL wrap_setup_ptr got %0d want 2", dut_rr.ptr); else passed++;
    rr.in_valid = 4'b1010;
    #1;
    for (int k = 0; k < 3; k++) begin
      checks++; if (rr.in_ready !== (4'b0001 << es[k])) $display("FAIL wrap_in_ready[%0d] got %b want %b", k, rr.in_ready, 4'b0001 << es[k]); else passed++;
      step();
      checks++; if (rr.out_src !== es[k] || rr.out_data !== ed[k])
        $display("FAIL wrap_out[%0d] got s=%0d d=%h want s=%0d d=%h", k, rr.out_src, rr.out_data, es[k], ed[k]); else passed++;
    end
    rr.in_valid = 4'h0;
  endtask

  task automatic test_drain_refill();
    rr.in_data[1*32 +: 32] = 32'h12345678;
    rr.in_valid = 4'b0010; rr.out_ready = 1'b1;
    #1;
    checks++; if (rr.out_valid !== 1'b1 || rr.in_ready !== 4'b0010)
      $display("FAIL refill_pre got v=%b r=%b want v=1 r=0010", rr.out_valid, rr.in_ready); else passed++;
    step();
    checks++; if (rr.out_valid !== 1'b1 || rr.out_data !== 32'h12345678 || rr.out_src !== 2'd1)
      $display("FAIL refill_out got v=%b d=%h s=%0d want v=1 d=12345678 s=1", rr.out_valid, rr.out_data, rr.out_src); else passed++;
    rr.in_valid = 4'h0;
  endtask

  task automatic test_reset_mid();
    rr.in_valid = 4'b0100;
    step();
    rr.in_valid = 4'h0; rr.out_ready = 1'b0;
    #1;
    checks++; if (rr.out_valid !== 1'b1 || dut_rr.ptr !== 2'd3)
      $display("FAIL rstmid_setup got v=%b ptr=%0d want v=1 ptr=3", rr.out_valid, dut_rr.ptr); else passed++;
    rst = 1'b1;
    step();
    checks++; if (rr.out_valid !== 1'b0 || rr.out_data !== 32'h0 || rr.out_src !== 2'd0 || dut_rr.ptr !== 2'd0)
      $display("FAIL rstmid_out got v=%b d=%h s=%0d ptr=%0d want 0 0 0 0", rr.out_valid, rr.out_data, rr.out_src, dut_rr.ptr); else passed++;
    rst = 1'b0;
    rr.in_valid = 4'hF; rr.out_ready = 1'b1;
    #1;
    checks++; if (rr.in_ready !== 4'b0001) $display("FAIL rstmid_grant got %b want 0001", rr.in_ready); else passed++;
    step();
    checks++; if (rr.out_src !== 2'd0 || rr.out_data !== 32'h000000FF)
      $display("FAIL rstmid_first got s=%0d d=%h want s=0 d=000000ff", rr.out_src, rr.out_data); else passed++;
    rr.in_valid = 4'h0;
  endtask

  task automatic test_fixed_prio();
    fp.in_data[0*32 +: 32] = 32'hA0A0A0A0;
    fp.in_data[2*32 +: 32] = 32'hC2C2C2C2;
    fp.in_valid = 4'b0101; fp.out_ready = 1'b1;
    #1;
    for (int k = 0; k < 4; k++) begin
      checks++; if (fp.in_ready !== 4'b0001) $display("FAIL fp_in_ready[%0d] got %b want 0001", k, fp.in_ready); else passed++;
      step();
      checks++; if (fp.out_valid !== 1'b1 || fp.out_src !== 2'd0 || fp.out_data !== 32'hA0A0A0A0)
        $display("FAIL fp_out[%0d] got v=%b s=%0d d=%h want v=1 s=0 d=a0a0a0a0", k, fp.out_valid, fp.out_src, fp.out_data); else passed++;
    end
    fp.in_valid = 4'b0100;
    #1;
    checks++; if (fp.in_ready !== 4'b0100) $display("FAIL fp_drop_ready got %b want 0100", fp.in_ready); else passed++;
    step();
    checks++; if (fp.out_src !== 2'd2 || fp.out_data !== 32'hC2C2C2C2 || dut_fp.ptr !== 2'd0)
      $display("FAIL fp_drop_out got s=%0d d=%h ptr=%0d want s=2 d=c2c2c2c2 ptr=0", fp.out_src, fp.out_data, dut_fp.ptr); else passed++;
    fp.in_valid = 4'h0;
  endtask

  task automatic test_n3_wrap();
    logic [7:0] dv [3];
    logic [1:0] es [5];
    dv = '{8'h10, 8'h21, 8'h32};
    es = '{2'd0, 2'd1, 2'd2, 2'd0, 2'd1};
    n3.in_data = {dv[2], dv[1], dv[0]};
    n3.in_valid = 3'b111; n3.out_ready = 1'b1;
    #1;
    for (int k = 0; k < 5; k++) begin
      checks++; if (n3.in_ready !== (3'b001 << es[k])) $display("FAIL n3_in_ready[%0d] got %b want %b", k, n3.in_ready, 3'b001 << es[k]); else passed++;
      step();
      checks++; if (n3.out_src !== es[k] || n3.out_data !== dv[es[k]])
        $display("FAIL n3_out[%0d] got s=%0d d=%h want s=%0d d=%h", k, n3.out_src, n3.out_data, es[k], dv[es[k]]); else passed++;
    end
    n3.in_valid = 3'b000;
  endtask

  initial begin
    rst = 1'b1;
    rr.in_valid = '0; rr.in_data = '0; rr.out_ready = 1'b0;
    fp.in_valid = '0; fp.in_data = '0; fp.out_ready = 1'b0;
    n3.in_valid = '0; n3.in_data = '0; n3.out_ready = 1'b0;
    test_reset();
    test_round_robin();
    test_stall();
    test_wrap();
    test_drain_refill();
    test_reset_mid();
    test_fixed_prio();
    test_n3_wrap();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule

// File: doc/arb_mux_reg.md
# arb_mux_reg

Parametrised N-way registered arbitration multiplexer with valid/ready handshakes on every input channel and on the output. Each cycle it selects one valid requester, round-robin or fixed-priority, and captures its data into a single output register, reporting the source index alongside. It is the sequential successor to the combinational mux family. It is used wherever several producers (functional units, issue slots) share one downstream port, e.g. the common data bus write-back path.

## Interface

- N, default 4: number of input channels, at least 2.
- WIDTH, default 32: data width per channel.
- FIXED_PRIO, default 0: 0 selects round-robin arbitration; 1 selects fixed priority, where the lowest index wins.
- SEL_W, derived, equal to max(1, $clog2(N)): width of the source index. Not overridable.

- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  synchronous reset, active-high.
- in_valid  input  N  bit i: channel i presents data.
- in_data  input  N*WIDTH  channel i occupies bits [i*WIDTH +: WIDTH].
- in_ready  output  N  one-hot or zero; bit i is 1 when channel i is granted and the block can accept.
- out_valid  output  1  output register holds a valid item.
- out_data  output  WIDTH  registered data of the granted channel.
- out_src  output  SEL_W  index of the channel that supplied out_data.
- out_ready  input  1  consumer accepts out_data this cycle.

## Operation

- Reset values: out_valid=0, out_data=0, out_src=0, round-robin pointer ptr=0. in_ready is all zeros during the cycle rst is high.
- can_accept = !out_valid || out_ready. The output register may be refilled in the same cycle it drains.
- Grant (combinational):
  - Round-robin: the first i with in_valid[i]=1, searching from ptr upward modulo N.
  - Fixed priority: the lowest i with in_valid[i]=1.
  - No valid input: no grant.
- in_ready[g] = can_accept && grant exists && g == granted index. All other bits are 0.
- Transfer in: a transfer on channel g happens when in_valid[g] && in_ready[g]. On that clock edge:
  - out_data ← channel g data, out_src ← g, out_valid ← 1.
  - In round-robin mode only, ptr ← (g+1) mod N. When g = N-1, ptr wraps to 0.
- Drain without refill: out_valid && out_ready with no input transfer → out_valid ← 0. out_data and out_src keep their old values.
- Stall: out_valid && !out_ready → out_data, out_src and out_valid hold, and in_ready is all zeros. ptr does not move while stalled.
- ptr advances only on an accepted transfer. It never moves on idle cycles or on cycles where requesters are present but not accepted.
- In fixed-priority mode ptr stays at 0 and is unused.
- Inputs may drop valid without a handshake. The grant is recomputed every cycle, so there is no grant lock.
- N not a power of two: out_src values at or above N never occur, and the pointer wrap is modulo N, not 2^SEL_W.

## Timing

- Latency: input data accepted on edge k is visible on out_data/out_valid after edge k. It can be consumed by the downstream in the cycle following edge k.
- Throughput: one item per cycle when out_ready is held high.
- No combinational path from in_data to out_data.
- Combinational paths exist from in_valid, out_ready and ptr to in_ready. A requester must not make in_valid depend on in_ready.
- Reset mid-operation: a held out_valid item is discarded and ptr returns to 0 on the edge where rst=1. The first post-reset grant searches from channel 0.
- rst has priority over any simultaneous transfer on the same edge.

## Test plan

- Reset, then N=4, WIDTH=32, RR mode, all four channels valid with data 0x000000FF, 0x0000FF00, 0x00FF0000, 0xFF000000, out_ready=1 → out_src sequence 0,1,2,3,0 on consecutive cycles, with matching out_data and out_valid=1 from the first post-grant cycle.
- Only channel 2 valid (0xDEADBEEF) with out_ready=0 for 3 cycles → out_valid=1, out_data=0xDEADBEEF, out_src=2 held for all 3 cycles, in_ready=0000 after the first capture. Then out_ready=1 → one drain; ptr=3.
- Channels 1 and 3 valid with ptr=2 → channel 3 granted first, then 1 (wrap), then 3. Channels 0 and 2 never see in_ready.
- FIXED_PRIO=1, channels 0 and 2 continuously valid, out_ready=1 → out_src=0 on every cycle and in_ready[2] never asserted. Drop channel 0 → out_src=2 on the next capture.
- Simultaneous drain and refill: out_valid=1, out_ready=1, channel 1 valid with 0x12345678 → out_valid stays 1 and out_data becomes 0x12345678 after the edge, with no bubble.
- Assert rst while out_valid=1 and out_ready=0 with ptr=3 → after the edge out_valid=0, out_data=0, out_src=0, ptr=0. Next grant with all channels valid is channel 0.
